// File: rtl/aes_seq_pkg.sv
// rtl/aes_seq_pkg.sv - states, kernel IDs and ownership helpers for the AES round sequencer
package aes_seq_pkg;

  typedef enum logic [2:0] {
    IDLE, ARK0, SBSR, MCARK, FSBSR, FARK, DONE
  } state_t;

  localparam logic [1:0] KID_SBSR  = 2'd0;
  localparam logic [1:0] KID_MCARK = 2'd1;
  localparam logic [1:0] KID_ARK   = 2'd2;

  typedef struct packed {
    logic       valid;
    logic [1:0] kid;
  } owner_t;

  // Both ARK invocations share one kernel, as do the normal and final SBSR.
  function automatic owner_t owner_of(input state_t s);
    owner_t o;
    o.valid = 1'b1;
    o.kid   = KID_ARK;
    case (s)
      ARK0, FARK:  o.kid = KID_ARK;
      SBSR, FSBSR: o.kid = KID_SBSR;
      MCARK:       o.kid = KID_MCARK;
      default: begin
        o.valid = 1'b0;
        o.kid   = KID_SBSR;
      end
    endcase
    return o;
  endfunction

  function automatic logic [2:0] kid_onehot(input logic [1:0] kid);
    return 3'b001 << kid;
  endfunction

endpackage

// File: rtl/aes_mem_port_mux.sv
// rtl/aes_mem_port_mux.sv - owner-selected 3:1 mux for one statemt RAM port with conflict detect
module aes_mem_port_mux
  import aes_seq_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  owner_t              owner,
  input  logic [3*ADDR_W-1:0] kern_addr,
  input  logic [2:0]          kern_ce,
  input  logic [2:0]          kern_we,
  input  logic [3*DATA_W-1:0] kern_d,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_ce,
  output logic                mem_we,
  output logic [DATA_W-1:0]   mem_d,
  output logic                conflict
);

  logic [2:0] own_mask;

  always_comb begin
    own_mask = owner.valid ? kid_onehot(owner.kid) : 3'b000;
    mem_addr = '0;
    mem_d    = '0;
    if (owner.valid) begin
      case (owner.kid)
        KID_SBSR: begin
          mem_addr = kern_addr[0 +: ADDR_W];
          mem_d    = kern_d[0 +: DATA_W];
        end
        KID_MCARK: begin
          mem_addr = kern_addr[ADDR_W +: ADDR_W];
          mem_d    = kern_d[DATA_W +: DATA_W];
        end
        default: begin
          mem_addr = kern_addr[2*ADDR_W +: ADDR_W];
          mem_d    = kern_d[2*DATA_W +: DATA_W];
        end
      endcase
    end
    // Non-owner requests never reach the RAM; they only raise the flag.
    mem_ce   = |(kern_ce & own_mask);
    mem_we   = |(kern_we & own_mask);
    conflict = |(kern_ce & ~own_mask);
  end

endmodule

// File: rtl/aes_round_sequencer.sv
// rtl/aes_round_sequencer.sv - sequences SBSR/MCARK/ARK kernels through a full AES cipher
module aes_round_sequencer
  import aes_seq_pkg::*;
#(
  parameter int NR     = 10,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [3:0]          round,
  output logic [2:0]          kern_start,
  input  logic [2:0]          kern_ready,
  input  logic [2:0]          kern_done,
  output logic [3:0]          kern_n,
  input  logic [3*ADDR_W-1:0] kern_addr0,
  input  logic [3*ADDR_W-1:0] kern_addr1,
  input  logic [2:0]          kern_ce0,
  input  logic [2:0]          kern_ce1,
  input  logic [2:0]          kern_we0,
  input  logic [2:0]          kern_we1,
  input  logic [3*DATA_W-1:0] kern_d0,
  input  logic [3*DATA_W-1:0] kern_d1,
  output logic [ADDR_W-1:0]   mem_addr0,
  output logic [ADDR_W-1:0]   mem_addr1,
  output logic                mem_ce0,
  output logic                mem_ce1,
  output logic                mem_we0,
  output logic                mem_we1,
  output logic [DATA_W-1:0]   mem_d0,
  output logic [DATA_W-1:0]   mem_d1,
  output logic                err_conflict
);

  localparam logic [3:0] LAST_MC = 4'(NR - 1);
  localparam logic [3:0] FINAL_N = 4'(NR);

  state_t     state;
  owner_t     own;
  logic       step;
  logic       conflict0;
  logic       conflict1;

  assign own    = owner_of(state);
  assign step   = own.valid && |(kern_done & kid_onehot(own.kid));
  assign kern_n = round;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state        <= IDLE;
      round        <= 4'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      kern_start   <= 3'b000;
      err_conflict <= 1'b0;
    end else begin
      done <= 1'b0;
      if (conflict0 || conflict1) err_conflict <= 1'b1;
      // Each start is held only until its kernel reports ready.
      kern_start <= kern_start & ~kern_ready;
      case (state)
        IDLE: if (start) begin
          state        <= ARK0;
          round        <= 4'd0;
          busy         <= 1'b1;
          kern_start   <= kid_onehot(KID_ARK);
          err_conflict <= 1'b0;
        end
        ARK0: if (step) begin
          state      <= SBSR;
          round      <= 4'd1;
          kern_start <= kid_onehot(KID_SBSR);
        end
        SBSR: if (step) begin
          state      <= MCARK;
          kern_start <= kid_onehot(KID_MCARK);
        end
        MCARK: if (step) begin
          kern_start <= kid_onehot(KID_SBSR);
          if (round == LAST_MC) begin
            state <= FSBSR;
            round <= FINAL_N;
          end else begin
            state <= SBSR;
            round <= round + 4'd1;
          end
        end
        FSBSR: if (step) begin
          state      <= FARK;
          kern_start <= kid_onehot(KID_ARK);
        end
        FARK: if (step) begin
          state      <= DONE;
          done       <= 1'b1;
          busy       <= 1'b0;
          kern_start <= 3'b000;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  aes_mem_port_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port0 (
    .owner    (own),
    .kern_addr(kern_addr0),
    .kern_ce  (kern_ce0),
    .kern_we  (kern_we0),
    .kern_d   (kern_d0),
    .mem_addr (mem_addr0),
    .mem_ce   (mem_ce0),
    .mem_we   (mem_we0),
    .mem_d    (mem_d0),
    .conflict (conflict0)
  );

  aes_mem_port_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port1 (
    .owner    (own),
    .kern_addr(kern_addr1),
    .kern_ce  (kern_ce1),
    .kern_we  (kern_we1),
    .kern_d   (kern_d1),
    .mem_addr (mem_addr1),
    .mem_ce   (mem_ce1),
    .mem_we   (mem_we1),
    .mem_d    (mem_d1),
    .conflict (conflict1)
  );

endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb/tb_aes_round_sequencer.sv - bench for aes_round_sequencer (NR=10 and NR=14 instances)
module tb_aes_round_sequencer;

  localparam int AW = 5;
  localparam int DW = 32;

  typedef struct {
    int kid;
    int n_acc;
    int n_done;
    int hold;
    int rdy;
    int lat;
    int acc_cyc;
    int done_cyc;
  } inv_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic            start [2];
  logic            busy_o [2];
  logic            done_o [2];
  logic [3:0]      round_o [2];
  logic [3:0]      kn [2];
  logic [2:0]      ks [2];
  logic [2:0]      kr [2];
  logic [2:0]      kdn [2];
  logic [3*AW-1:0] kaddr0 [2];
  logic [3*AW-1:0] kaddr1 [2];
  logic [2:0]      kce0 [2];
  logic [2:0]      kce1 [2];
  logic [2:0]      kwe0 [2];
  logic [2:0]      kwe1 [2];
  logic [3*DW-1:0] kdat0 [2];
  logic [3*DW-1:0] kdat1 [2];
  logic [AW-1:0]   maddr0 [2];
  logic [AW-1:0]   maddr1 [2];
  logic            mce0 [2];
  logic            mce1 [2];
  logic            mwe0 [2];
  logic            mwe1 [2];
  logic [DW-1:0]   md0 [2];
  logic [DW-1:0]   md1 [2];
  logic            err [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    aes_round_sequencer #(.NR(g == 0 ? 10 : 14), .ADDR_W(AW), .DATA_W(DW)) dut (
      .ap_clk(clk), .ap_rst_n(rst_n), .start(start[g]),
      .busy(busy_o[g]), .done(done_o[g]), .round(round_o[g]),
      .kern_start(ks[g]), .kern_ready(kr[g]), .kern_done(kdn[g]), .kern_n(kn[g]),
      .kern_addr0(kaddr0[g]), .kern_addr1(kaddr1[g]),
      .kern_ce0(kce0[g]), .kern_ce1(kce1[g]), .kern_we0(kwe0[g]), .kern_we1(kwe1[g]),
      .kern_d0(kdat0[g]), .kern_d1(kdat1[g]),
      .mem_addr0(maddr0[g]), .mem_addr1(maddr1[g]),
      .mem_ce0(mce0[g]), .mem_ce1(mce1[g]), .mem_we0(mwe0[g]), .mem_we1(mwe1[g]),
      .mem_d0(md0[g]), .mem_d1(md1[g]), .err_conflict(err[g])
    );
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural HLS kernel models: ready after rdy cycles, done after lat cycles.
  int   act [2][3];
  int   cnt [2][3];
  int   hold [2][3];
  inv_t cur [2][3];
  inv_t inv_log [$];
  int   lat_fix [3];
  int   rdy_fix [3];
  bit   rand_mode;
  int   done_cnt [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst_n && done_o[d] === 1'b1) done_cnt[d] = done_cnt[d] + 1;
      for (int k = 0; k < 3; k++) begin
        kr[d][k]  = 1'b0;
        kdn[d][k] = 1'b0;
        if (!rst_n) begin
          act[d][k] = 0;
        end else begin
          if (act[d][k] == 0 && ks[d][k] === 1'b1) begin
            act[d][k] = 1;
            cnt[d][k] = 0;
            hold[d][k] = 0;
            cur[d][k].kid = k;
            cur[d][k].n_acc = int'(kn[d]);
            cur[d][k].acc_cyc = cyc;
            if (rand_mode) begin
              cur[d][k].lat = $urandom_range(5, 0);
              cur[d][k].rdy = $urandom_range(cur[d][k].lat, 0);
            end else begin
              cur[d][k].lat = lat_fix[k];
              cur[d][k].rdy = rdy_fix[k];
            end
          end
          if (act[d][k] == 1) begin
            if (ks[d][k] === 1'b1) hold[d][k] = hold[d][k] + 1;
            kr[d][k]  = (cnt[d][k] == cur[d][k].rdy);
            kdn[d][k] = (cnt[d][k] == cur[d][k].lat);
            if (cnt[d][k] == cur[d][k].lat) begin
              cur[d][k].n_done = int'(kn[d]);
              cur[d][k].done_cyc = cyc;
              cur[d][k].hold = hold[d][k];
              inv_log.push_back(cur[d][k]);
              act[d][k] = 0;
            end
            cnt[d][k] = cnt[d][k] + 1;
          end
        end
      end
    end
  end

  // Reference cipher schedule: ARK(0), {SBSR(r), MCARK(r)} r=1..NR-1, SBSR(NR), ARK(NR).
  function automatic int exp_kid(input int i, input int nr);
    if (i == 0 || i == 2 * nr) return 2;
    return (i % 2 == 1) ? 0 : 1;
  endfunction

  function automatic int exp_n(input int i, input int nr);
    if (i == 0) return 0;
    if (i == 2 * nr) return nr;
    return (i + 1) / 2;
  endfunction

  task automatic pulse_start(input int d, output int sc);
    @(negedge clk);
    start[d] = 1'b1;
    sc = cyc;
    @(negedge clk);
    start[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, output int dc, output bit ok);
    ok = 1'b0;
    dc = -1;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(negedge clk);
      if (done_o[d] === 1'b1) begin
        ok = 1'b1;
        dc = cyc;
      end
    end
  endtask

  task automatic test_reset;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({busy_o[d], done_o[d], round_o[d], ks[d], err[d]} !== 10'b0) begin
        errors++;
        $display("FAIL reset_ctrl[%0d]: busy=%b done=%b round=%0d kstart=%b err=%b, expected all 0",
                 d, busy_o[d], done_o[d], round_o[d], ks[d], err[d]);
      end
      checks++;
      if ({mce0[d], mwe0[d], maddr0[d], md0[d], mce1[d], mwe1[d], maddr1[d], md1[d]} !== '0) begin
        errors++;
        $display("FAIL reset_mem[%0d]: addr0=%0h d0=%0h ce0=%b ce1=%b, expected 0", d, maddr0[d], md0[d], mce0[d], mce1[d]);
      end
    end
  endtask

  task automatic test_full_run;
    int sc, dc, d0;
    bit ok;
    rand_mode = 1'b0;
    lat_fix = '{3, 3, 3};
    rdy_fix = '{0, 0, 0};
    inv_log.delete();
    d0 = done_cnt[0];
    pulse_start(0, sc);
    checks++;
    if (busy_o[0] !== 1'b1 || ks[0] !== 3'b100 || round_o[0] !== 4'd0) begin
      errors++;
      $display("FAIL first_start: busy=%b kstart=%b round=%0d, expected 1 100 0", busy_o[0], ks[0], round_o[0]);
    end
    repeat (5) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0, dc, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL full_timeout: done=0, expected 1"); end
    checks++;
    if (dc - sc !== 85) begin errors++; $display("FAIL full_latency: got %0d, expected 85", dc - sc); end
    checks++;
    if (busy_o[0] !== 1'b0) begin errors++; $display("FAIL busy_at_done: got %b, expected 0", busy_o[0]); end
    @(negedge clk);
    checks++;
    if (done_o[0] !== 1'b0) begin errors++; $display("FAIL done_pulse_width: got %b, expected 0", done_o[0]); end
    checks++;
    if (inv_log.size() !== 21) begin errors++; $display("FAIL full_count: got %0d, expected 21", inv_log.size()); end
    for (int i = 0; i < inv_log.size(); i++) begin
      checks++;
      if (inv_log[i].kid != exp_kid(i, 10) || inv_log[i].n_acc != exp_n(i, 10)) begin
        errors++;
        $display("FAIL full_seq[%0d]: kid=%0d n=%0d, expected kid=%0d n=%0d",
                 i, inv_log[i].kid, inv_log[i].n_acc, exp_kid(i, 10), exp_n(i, 10));
      end
    end
    checks++;
    if (done_cnt[0] - d0 !== 1) begin errors++; $display("FAIL full_done_pulses: got %0d, expected 1", done_cnt[0] - d0); end
  endtask

  task automatic test_ready_delay;
    int sc, dc;
    bit ok;
    lat_fix = '{3, 6, 3};
    rdy_fix = '{0, 4, 0};
    inv_log.delete();
    pulse_start(0, sc);
    wait_done(0, dc, ok);
    checks++;
    if (!ok || inv_log.size() !== 21) begin
      errors++;
      $display("FAIL rdy_count: ok=%b invocations=%0d, expected 1 21", ok, inv_log.size());
    end
    for (int i = 0; i < inv_log.size(); i++) begin
      if (inv_log[i].kid == 1) begin
        checks++;
        if (inv_log[i].hold != 5 || inv_log[i].n_done != inv_log[i].n_acc || inv_log[i].n_acc != exp_n(i, 10)) begin
          errors++;
          $display("FAIL rdy_mcark[%0d]: hold=%0d n_acc=%0d n_done=%0d, expected hold=5 n=%0d",
                   i, inv_log[i].hold, inv_log[i].n_acc, inv_log[i].n_done, exp_n(i, 10));
        end
      end
      if (i > 0) begin
        checks++;
        if (inv_log[i].acc_cyc != inv_log[i-1].done_cyc + 1) begin
          errors++;
          $display("FAIL rdy_gap[%0d]: start cycle %0d, expected %0d", i, inv_log[i].acc_cyc, inv_log[i-1].done_cyc + 1);
        end
      end
    end
    lat_fix = '{3, 3, 3};
    rdy_fix = '{0, 0, 0};
  endtask

  task automatic test_conflict;
    int sc, dc;
    bit ok;
    @(negedge clk);
    kaddr0[0] = {5'd7, 5'd0, 5'd3};
    kdat0[0]  = {32'hA5, 32'h0, 32'h5A};
    kwe0[0]   = 3'b111;
    #1;
    checks++;
    if (maddr0[0] !== '0 || md0[0] !== '0 || mce0[0] !== 1'b0 || mwe0[0] !== 1'b0) begin
      errors++;
      $display("FAIL idle_mem: addr=%0h d=%0h ce=%b we=%b, expected 0", maddr0[0], md0[0], mce0[0], mwe0[0]);
    end
    kwe0[0] = 3'b000;
    lat_fix[2] = 8;
    pulse_start(0, sc);
    kce0[0] = 3'b101;
    kwe0[0] = 3'b100;
    #1;
    checks++;
    if (maddr0[0] !== 5'd7 || md0[0] !== 32'hA5 || mce0[0] !== 1'b1 || mwe0[0] !== 1'b1) begin
      errors++;
      $display("FAIL owner_route: addr=%0d d=%0h ce=%b we=%b, expected 7 a5 1 1", maddr0[0], md0[0], mce0[0], mwe0[0]);
    end
    checks++;
    if (err[0] !== 1'b0) begin errors++; $display("FAIL err_early: got %b, expected 0", err[0]); end
    @(negedge clk);
    kce0[0] = 3'b000;
    kwe0[0] = 3'b000;
    checks++;
    if (err[0] !== 1'b1) begin errors++; $display("FAIL err_set: got %b, expected 1", err[0]); end
    wait_done(0, dc, ok);
    checks++;
    if (!ok || err[0] !== 1'b1) begin errors++; $display("FAIL err_sticky: ok=%b err=%b, expected 1 1", ok, err[0]); end
    pulse_start(0, sc);
    checks++;
    if (err[0] !== 1'b0) begin errors++; $display("FAIL err_clear_on_start: got %b, expected 0", err[0]); end
    kce1[0] = 3'b010;
    #1;
    checks++;
    if (mce1[0] !== 1'b0) begin errors++; $display("FAIL port1_drop: ce1=%b, expected 0", mce1[0]); end
    @(negedge clk);
    kce1[0] = 3'b000;
    checks++;
    if (err[0] !== 1'b1) begin errors++; $display("FAIL port1_err: got %b, expected 1", err[0]); end
    lat_fix[2] = 3;
    wait_done(0, dc, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL conflict_timeout: done=0, expected 1"); end
  endtask

  task automatic test_start_held;
    int dc, rc;
    bit ok, found;
    inv_log.delete();
    @(negedge clk);
    start[0] = 1'b1;
    wait_done(0, dc, ok);
    checks++;
    if (!ok || inv_log.size() !== 21) begin
      errors++;
      $display("FAIL held_first_run: ok=%b invocations=%0d, expected 1 21", ok, inv_log.size());
    end
    found = 1'b0;
    rc = -1;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (ks[0][2] === 1'b1) begin found = 1'b1; rc = cyc; end
    end
    start[0] = 1'b0;
    checks++;
    if (!found || rc != dc + 2) begin
      errors++;
      $display("FAIL held_restart: restart cycle %0d, expected %0d", rc, dc + 2);
    end
    wait_done(0, dc, ok);
    checks++;
    if (!ok || inv_log.size() !== 42) begin
      errors++;
      $display("FAIL held_second_run: ok=%b invocations=%0d, expected 1 42", ok, inv_log.size());
    end
  endtask

  task automatic test_async_reset;
    int sc, dc;
    bit ok, found;
    pulse_start(0, sc);
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      if (ks[0][1] === 1'b1 && round_o[0] == 4'd5) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL reach_round5: not reached, expected MCARK round 5"); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy_o[0], done_o[0], round_o[0], ks[0], err[0], mce0[0], mwe0[0], maddr0[0]} !== '0) begin
      errors++;
      $display("FAIL async_reset: busy=%b round=%0d kstart=%b ce0=%b addr0=%0h, expected 0",
               busy_o[0], round_o[0], ks[0], mce0[0], maddr0[0]);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    inv_log.delete();
    pulse_start(0, sc);
    wait_done(0, dc, ok);
    checks++;
    if (!ok || inv_log.size() !== 21 || inv_log[0].kid != 2 || inv_log[0].n_acc != 0) begin
      errors++;
      $display("FAIL post_reset_run: ok=%b invocations=%0d, expected fresh 21-invocation run from round 0",
               ok, inv_log.size());
    end
  endtask

  task automatic test_nr14;
    int sc, dc;
    bit ok;
    inv_log.delete();
    pulse_start(1, sc);
    wait_done(1, dc, ok);
    checks++;
    if (!ok || inv_log.size() !== 29) begin
      errors++;
      $display("FAIL nr14_count: ok=%b invocations=%0d, expected 1 29", ok, inv_log.size());
    end
    for (int i = 0; i < inv_log.size(); i++) begin
      checks++;
      if (inv_log[i].kid != exp_kid(i, 14) || inv_log[i].n_acc != exp_n(i, 14)) begin
        errors++;
        $display("FAIL nr14_seq[%0d]: kid=%0d n=%0d, expected kid=%0d n=%0d",
                 i, inv_log[i].kid, inv_log[i].n_acc, exp_kid(i, 14), exp_n(i, 14));
      end
    end
    checks++;
    if (dc - sc !== 29 * 3 + 30) begin errors++; $display("FAIL nr14_latency: got %0d, expected %0d", dc - sc, 29 * 3 + 30); end
  endtask

  task automatic test_random;
    int sc, dc, sum;
    bit ok;
    rand_mode = 1'b1;
    for (int run = 0; run < 3; run++) begin
      inv_log.delete();
      pulse_start(0, sc);
      wait_done(0, dc, ok);
      checks++;
      if (!ok || inv_log.size() !== 21) begin
        errors++;
        $display("FAIL rand_count[%0d]: ok=%b invocations=%0d, expected 1 21", run, ok, inv_log.size());
      end
      sum = 0;
      for (int i = 0; i < inv_log.size(); i++) begin
        sum += inv_log[i].lat;
        checks++;
        if (inv_log[i].kid != exp_kid(i, 10) || inv_log[i].n_acc != exp_n(i, 10) ||
            inv_log[i].n_done != inv_log[i].n_acc || inv_log[i].hold != inv_log[i].rdy + 1 ||
            inv_log[i].acc_cyc != ((i == 0) ? sc + 1 : inv_log[i-1].done_cyc + 1)) begin
          errors++;
          $display("FAIL rand_inv[%0d.%0d]: kid=%0d n=%0d/%0d hold=%0d rdy=%0d start=%0d, expected kid=%0d n=%0d",
                   run, i, inv_log[i].kid, inv_log[i].n_acc, inv_log[i].n_done, inv_log[i].hold,
                   inv_log[i].rdy, inv_log[i].acc_cyc, exp_kid(i, 10), exp_n(i, 10));
        end
      end
      checks++;
      if (dc - sc !== sum + 22) begin errors++; $display("FAIL rand_latency[%0d]: got %0d, expected %0d", run, dc - sc, sum + 22); end
    end
    rand_mode = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0;
      kaddr0[d] = '0; kaddr1[d] = '0;
      kce0[d] = '0; kce1[d] = '0; kwe0[d] = '0; kwe1[d] = '0;
      kdat0[d] = '0; kdat1[d] = '0;
    end
    rand_mode = 1'b0;
    lat_fix = '{3, 3, 3};
    rdy_fix = '{0, 0, 0};
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_full_run();
    test_ready_delay();
    test_conflict();
    test_start_held();
    test_async_reset();
    test_nr14();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
